counter_mod_updown: RTL and testbench
=====================================

Name: counter_mod_updown

Overview:
Parametrised modulo-MOD up/down counter, the next generation of the team's N-bit counter.
Adds count enable, direction control, synchronous parallel load, and a runtime wrap/saturate mode.
Adds a registered terminal-count pulse and a sticky overflow flag.
Used as a building block for timers, prescalers and address generators.

Parameters:
N, 7, counter width in bits.
MOD, 2**N, modulus: count range is 0..MOD-1; legal range 2 <= MOD <= 2**N.

Ports:
clk  input  1  clock; all state updates on rising edge.
clr  input  1  reset, asynchronous, active-high.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous parallel load.
din  input  N  load value.
sat  input  1  mode: 0 = wrap at boundary, 1 = saturate at boundary.
ovf_clr  input  1  synchronous clear of sticky overflow flag.
count  output  N  current count, [N-1:0], registered.
tc  output  1  terminal-count pulse, registered.
ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset: clk is the single clock; clr is asynchronous and active-high.
  - clr=1 forces count=0, tc=0, ovf=0 immediately, independent of clk.
  - Outputs hold these values while clr=1.
  - First update is on the first rising clk edge after clr deasserts.
- Next-count priority per rising edge: load > en > hold.
- load=1:
  - count <= din if din < MOD, else count <= MOD-1 (clamp).
  - tc <= 0; ovf unaffected by the load itself.
- load=0, en=1, up=1:
  - count < MOD-1: count <= count+1, tc <= 0.
  - count == MOD-1, sat=0: count <= 0, tc <= 1, ovf <= 1.
  - count == MOD-1, sat=1: count holds MOD-1, tc <= 1, ovf <= 1.
- load=0, en=1, up=0:
  - count > 0: count <= count-1, tc <= 0.
  - count == 0, sat=0: count <= MOD-1, tc <= 1, ovf <= 1.
  - count == 0, sat=1: count holds 0, tc <= 1, ovf <= 1.
- load=0, en=0: count holds, tc <= 0.
- tc semantics:
  - High for exactly the one cycle following each enabled boundary step.
  - In saturate mode it re-asserts on every enabled cycle that attempts to pass the boundary.
- ovf semantics:
  - Set by any boundary event; cleared by ovf_clr=1 at a clock edge.
  - Set has priority over ovf_clr in the same cycle.
- Latency: every output changes one clock after its cause; no combinational input-to-output paths.
- Width rules:
  - Boundary compares and the din clamp use N+1-bit arithmetic, so MOD=2**N is handled correctly.
  - MOD-1 always fits in N bits.
- up and sat may change on any cycle; they take effect at the next edge.
- The counter never holds a value >= MOD.
- Illegal MOD (below 2 or above 2**N) is flagged at elaboration by a simulation-only check that reports and calls $finish.

Decomposition:
- Shared include file holds:
  - Mode encodings: MODE_WRAP=0, MODE_SAT=1.
  - Direction encodings: DIR_DOWN=0, DIR_UP=1.
- One sub-module is natural: counter_mod_next.
  - Purely combinational.
  - Inputs: count, up, sat, load, din, en.
  - Outputs: next count, boundary-hit flag.
  - Top level holds the three registers and the clr logic.

Test Plan:
Bench parameters: N=4, MOD=10.
1. Wrap up: clr pulse, then en=1, up=1, sat=0 for 12 edges -> count 0,1,..,9,0,1,2; tc high for one cycle after the 9->0 step only; ovf=1 from then on.
2. Wrap down: from count=0, en=1, up=0, sat=0 -> count 9,8,7; tc pulses once after the 0->9 step; ovf=1.
3. Saturate: load din=8, then en=1, up=1, sat=1 for 4 edges -> count 9,9,9,9; tc high on the 2nd, 3rd and 4th cycles; toggle up=0 -> count 8.
4. Load priority and clamp: load=1, en=1, din=13 -> count=9, tc=0; load din=3 -> count=3.
5. Async reset mid-count: assert clr between edges while count=6, ovf=1 -> count=0, ovf=0, tc=0 before the next edge; deassert -> counting resumes 1,2,... from the following edge.
6. ovf race: ovf=0, count=9, up=1, en=1, ovf_clr=1 on the same edge -> ovf=1; next edge with ovf_clr=1 and no boundary -> ovf=0.

Source files
------------

// File: rtl/counter_mod_updown_pkg.sv
// ----------------------------------------------------------------------------
// counter_mod_updown_pkg
//   Shared encodings for the modulo up/down counter family.
//   - MODE_WRAP / MODE_SAT : values of the 'sat' input
//   - DIR_DOWN  / DIR_UP   : values of the 'up' input
//   - mod_is_legal()       : elaboration-time range check for MOD
// ----------------------------------------------------------------------------
package counter_mod_updown_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // A modulus is usable when the range 0..m-1 has at least two values and
  // m-1 still fits in n bits.
  function automatic bit mod_is_legal(input int n, input int m);
    return (m >= 2) && (m <= (1 << n));
  endfunction

endpackage : counter_mod_updown_pkg

// File: rtl/counter_mod_next.sv
// ----------------------------------------------------------------------------
// counter_mod_next
//   Purely combinational next-state logic of the modulo up/down counter.
//   Ports:
//     count      in  [N-1:0]  current registered count
//     up         in           direction (DIR_UP / DIR_DOWN)
//     sat        in           boundary mode (MODE_WRAP / MODE_SAT)
//     load       in           parallel load request (highest priority)
//     din        in  [N-1:0]  load value, clamped to MOD-1
//     en         in           count enable
//     next_count out [N-1:0]  value to register on the next edge
//     hit        out          an enabled step tried to pass the boundary
// ----------------------------------------------------------------------------
module counter_mod_next
  import counter_mod_updown_pkg::*;
#(
  parameter int N   = 7,
  parameter int MOD = 2**N
) (
  input  logic [N-1:0] count,
  input  logic         up,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         en,
  output logic [N-1:0] next_count,
  output logic         hit
);

  // Compares are done one bit wider so that MOD = 2**N is representable.
  localparam logic [N:0]   MOD_X = (N+1)'(MOD);
  localparam logic [N:0]   MAX_X = (N+1)'(MOD - 1);
  localparam logic [N-1:0] MAX   = N'(MOD - 1);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    next_count = count;
    hit        = 1'b0;

    if (load) begin
      next_count = ({1'b0, din} < MOD_X) ? din : MAX;
    end else if (en) begin
      case (up)
        DIR_UP: begin
          if ({1'b0, count} < MAX_X) begin
            next_count = count + 1'b1;
          end else begin
            hit        = 1'b1;
            next_count = (sat == MODE_SAT) ? MAX : '0;
          end
        end
        DIR_DOWN: begin
          if (count != '0) begin
            next_count = count - 1'b1;
          end else begin
            hit        = 1'b1;
            next_count = (sat == MODE_WRAP) ? MAX : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : counter_mod_next

// File: rtl/counter_mod_updown.sv
// ----------------------------------------------------------------------------
// counter_mod_updown
//   Up/down counter over the range 0..MOD-1 with enable, synchronous load
//   (values above the range are clamped to the top value), runtime
//   wrap/saturate mode, registered terminal-count pulse and sticky overflow
//   flag. All outputs are registered.
//   Ports:
//     clk      in           rising-edge clock
//     clr      in           asynchronous active-high reset
//     en       in           count enable
//     up       in           1 = increment, 0 = decrement
//     load     in           synchronous parallel load (beats en)
//     din      in  [N-1:0]  load value
//     sat      in           0 = wrap at boundary, 1 = saturate
//     ovf_clr  in           synchronous clear of the sticky ovf flag
//     count    out [N-1:0]  current count, always below the modulus
//     tc       out          one-cycle pulse after each boundary step
//     ovf      out          sticky boundary flag
// ----------------------------------------------------------------------------
module counter_mod_updown
  import counter_mod_updown_pkg::*;
#(
  parameter int N   = 7,
  parameter int MOD = 2**N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         sat,
  input  logic         ovf_clr,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  // Reject an unusable modulus while elaborating; no hardware results.
  if (!mod_is_legal(N, MOD)) begin : g_bad_mod
    $fatal(1, "counter_mod_updown: MOD=%0d illegal for N=%0d (need 2..2**N)",
           MOD, N);
  end

  logic [N-1:0] next_count;
  logic         hit;

  counter_mod_next #(
    .N   (N),
    .MOD (MOD)
  ) u_next (
    .count      (count),
    .up         (up),
    .sat        (sat),
    .load       (load),
    .din        (din),
    .en         (en),
    .next_count (next_count),
    .hit        (hit)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all three registers sample the
      // same pre-edge values, independent of statement order.
      count <= next_count;
      // hit is only raised for an enabled, non-load step, so load and idle
      // cycles clear tc automatically.
      tc    <= hit;
      // A boundary event wins over a simultaneous clear request.
      if (hit) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule : counter_mod_updown

// File: tb/tb_counter_mod_updown.sv
// ----------------------------------------------------------------------------
// tb_counter_mod_updown
//   Self-checking bench for counter_mod_updown with N=4, MOD=10.
//   Directed scenarios compare against explicit expected sequences; the
//   random scenario compares against a modular-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_counter_mod_updown;

  localparam int N   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] din;
  logic         sat;
  logic         ovf_clr;
  logic [N-1:0] count;
  logic         tc;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_count = 0;
  bit m_tc    = 1'b0;
  bit m_ovf   = 1'b0;

  counter_mod_updown #(
    .N   (N),
    .MOD (MOD)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .up      (up),
    .load    (load),
    .din     (din),
    .sat     (sat),
    .ovf_clr (ovf_clr),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic model_zero();
    m_count = 0;
    m_tc    = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Advance one rising edge, update the model from the inputs seen at that
  // edge, and return 1 time unit later so outputs are sampled off the edge.
  task automatic tick();
    int nxt;
    bit boundary;
    boundary = 1'b0;
    nxt      = m_count;
    if (load) begin
      nxt = (int'(din) < MOD) ? int'(din) : MOD - 1;
    end else if (en) begin
      boundary = up ? (m_count == MOD - 1) : (m_count == 0);
      if (boundary && sat) nxt = m_count;
      else                 nxt = (m_count + (up ? 1 : MOD - 1)) % MOD;
    end
    @(posedge clk);
    if (clr) begin
      model_zero();
    end else begin
      m_count = nxt;
      m_tc    = boundary;
      if (boundary)     m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    en      = 1'b0;
    up      = 1'b1;
    load    = 1'b0;
    din     = '0;
    sat     = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Mid-cycle clear pulse.
  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    model_zero();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    idle_inputs();
    #3;
    checks++;
    if ({count, tc, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got count=%0d tc=%b ovf=%b, need 0 0 0", count, tc, ovf);
    end
    en = 1'b1;
    tick();
    checks++;
    if ({count, tc, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got count=%0d tc=%b ovf=%b, need 0 0 0", count, tc, ovf);
    end
    en  = 1'b0;
    clr = 1'b0;
    model_zero();
  endtask

  task automatic test_wrap_up();
    int exp_c;
    pulse_clr();
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_c = (i + 1) % MOD;
      checks++;
      if ({count, tc, ovf} !== {exp_c[N-1:0], (i == 9), (i >= 9)}) begin
        errors++;
        $display("FAIL wrap_up step %0d: got count=%0d tc=%b ovf=%b, need %0d %b %b",
                 i, count, tc, ovf, exp_c, (i == 9), (i >= 9));
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    int exp_c;
    load = 1'b1; din = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_c = 9 - i;
      checks++;
      if ({count, tc, ovf} !== {exp_c[N-1:0], (i == 0), 1'b1}) begin
        errors++;
        $display("FAIL wrap_down step %0d: got count=%0d tc=%b ovf=%b, need %0d %b 1",
                 i, count, tc, ovf, exp_c, (i == 0));
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    load = 1'b1; din = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({count, tc} !== {4'd9, (i >= 1)}) begin
        errors++;
        $display("FAIL saturate step %0d: got count=%0d tc=%b, need 9 %b",
                 i, count, tc, (i >= 1));
      end
    end
    up = 1'b0;
    tick();
    checks++;
    if ({count, tc} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL saturate_turn: got count=%0d tc=%b, need 8 0", count, tc);
    end
    idle_inputs();
  endtask

  task automatic test_load();
    load = 1'b1; en = 1'b1; din = 4'd13;
    tick();
    checks++;
    if ({count, tc} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL load_clamp: got count=%0d tc=%b, need 9 0", count, tc);
    end
    din = 4'd3;
    tick();
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL load_value: got count=%0d, need 3", count);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    load = 1'b1; din = 4'd5;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    tick();
    checks++;
    if ({count, ovf} !== {4'd6, 1'b1}) begin
      errors++;
      $display("FAIL async_pre: got count=%0d ovf=%b, need 6 1", count, ovf);
    end
    #2;
    clr = 1'b1;
    model_zero();
    #1;
    checks++;
    if ({count, tc, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_clr: got count=%0d tc=%b ovf=%b, need 0 0 0", count, tc, ovf);
    end
    tick();
    #2;
    clr = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (count !== N'(i)) begin
        errors++;
        $display("FAIL async_resume %0d: got count=%0d, need %0d", i, count, i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_ovf_race();
    pulse_clr();
    load = 1'b1; din = 4'd9;
    tick();
    checks++;
    if ({count, ovf} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL ovf_race_setup: got count=%0d ovf=%b, need 9 0", count, ovf);
    end
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; ovf_clr = 1'b1;
    tick();
    checks++;
    if ({count, tc, ovf} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_race_set: got count=%0d tc=%b ovf=%b, need 0 1 1", count, tc, ovf);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({count, tc, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_race_clear: got count=%0d tc=%b ovf=%b, need 0 0 0", count, tc, ovf);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (clr) begin
        clr = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        clr = 1'b1;
        model_zero();
      end
      load    = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      up      = $urandom_range(0, 1) != 0;
      sat     = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 5) == 0);
      din     = N'($urandom_range(0, 15));
      tick();
      checks++;
      if ({count, tc, ovf} !== {m_count[N-1:0], m_tc, m_ovf} || int'(count) >= MOD) begin
        errors++;
        $display("FAIL random cycle %0d: got count=%0d tc=%b ovf=%b, need %0d %b %b",
                 i, count, tc, ovf, m_count, m_tc, m_ovf);
      end
    end
    clr = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_async_reset();
    test_ovf_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_mod_updown
